// File: rtl/dcache_ctrl_pkg.sv
// Shared widths, state encoding and address-slicing helpers for the data-cache
// miss controller (2-way, 64-set, 16-byte lines).
package dcache_ctrl_pkg;

  localparam int ADDR_WIDTH        = 64;
  localparam int TAG_WIDTH         = 54;
  localparam int INDEX_WIDTH       = 6;
  localparam int OFFSET_WIDTH      = 4;
  localparam int AXI_RW_DATA_WIDTH = 128;
  localparam int HIT_WIDTH         = 2;
  localparam int NUM_SETS          = 1 << INDEX_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]        addr_t;
  typedef logic [TAG_WIDTH-1:0]         tag_t;
  typedef logic [INDEX_WIDTH-1:0]       idx_t;
  typedef logic [AXI_RW_DATA_WIDTH-1:0] line_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_RD   = 3'd1,
    S_WB_CAP  = 3'd2,
    S_WB_WAIT = 3'd3,
    S_RD_REQ  = 3'd4,
    S_REFRESH = 3'd5
  } state_e;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic idx_t addr_idx(input addr_t a);
    return a[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic addr_t line_addr(input tag_t t, input idx_t i);
    return {t, i, {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU request, data-array control and line-bus signals of the dcache controller.
// master = the controller, slave = CPU / data array / memory side.
interface dcache_ctrl_if;
  import dcache_ctrl_pkg::*;

  logic                 cache;
  logic                 sram_e;
  logic                 sram_we;
  addr_t                sram_addr;
  logic                 stall;

  logic [HIT_WIDTH-1:0] hit;
  logic                 lru;
  logic                 write_back;
  logic                 refresh;
  line_t                cacheline_new;
  line_t                cacheline_old;

  logic                 rd_req;
  addr_t                rd_addr;
  logic                 rd_valid;
  line_t                rd_data;

  logic                 wr_req;
  addr_t                wr_addr;
  line_t                wr_data;
  logic                 wr_done;

  modport master (
    input  cache, sram_e, sram_we, sram_addr, cacheline_old,
           rd_valid, rd_data, wr_done,
    output stall, hit, lru, write_back, refresh, cacheline_new,
           rd_req, rd_addr, wr_req, wr_addr, wr_data
  );

  modport slave (
    output cache, sram_e, sram_we, sram_addr, cacheline_old,
           rd_valid, rd_data, wr_done,
    input  stall, hit, lru, write_back, refresh, cacheline_new,
           rd_req, rd_addr, wr_req, wr_addr, wr_data
  );

endinterface

// File: rtl/dcache_tag.sv
// Tag/valid/dirty/MRU store for the 2-way cache: combinational compare against
// the looked-up address and victim selection for that set.
module dcache_tag
  import dcache_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  idx_t                 lookup_idx_i,
  input  tag_t                 lookup_tag_i,
  output logic [HIT_WIDTH-1:0] match_o,
  output logic                 victim_o,
  output logic                 victim_wb_o,
  output tag_t                 victim_tag_o,
  input  logic                 touch_i,
  input  logic                 touch_way_i,
  input  logic                 touch_dirty_i,
  input  logic                 clean_i,
  input  logic                 fill_i,
  input  logic                 upd_way_i,
  input  idx_t                 upd_idx_i,
  input  tag_t                 fill_tag_i
);

  tag_t                tag_q   [HIT_WIDTH][NUM_SETS];
  logic [NUM_SETS-1:0] valid_q [HIT_WIDTH];
  logic [NUM_SETS-1:0] dirty_q [HIT_WIDTH];
  logic [NUM_SETS-1:0] mru_q;
  logic                victim;

  // NOTE: the tag array is deliberately left out of reset; valid_q qualifies
  // every read of it, so a RAM without a reset port can hold it.
  always_ff @(posedge clk) begin
    if (fill_i) tag_q[upd_way_i][upd_idx_i] <= fill_tag_i;
  end

  // NOTE: state registers are written only with non-blocking assignments so
  // every reader in the same edge sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < HIT_WIDTH; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      mru_q <= '0;
    end else begin
      if (touch_i) begin
        mru_q[lookup_idx_i] <= touch_way_i;
        if (touch_dirty_i) dirty_q[touch_way_i][lookup_idx_i] <= 1'b1;
      end
      if (clean_i) dirty_q[upd_way_i][upd_idx_i] <= 1'b0;
      if (fill_i) begin
        valid_q[upd_way_i][upd_idx_i] <= 1'b1;
        dirty_q[upd_way_i][upd_idx_i] <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < HIT_WIDTH; w++) begin
      match_o[w] = valid_q[w][lookup_idx_i] && (tag_q[w][lookup_idx_i] == lookup_tag_i);
    end
  end

  // Invalid ways are filled first (way0 before way1), else the least recently used.
  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned and a latch cannot be inferred.
  always_comb begin
    victim = ~mru_q[lookup_idx_i];
    if (!valid_q[0][lookup_idx_i])      victim = 1'b0;
    else if (!valid_q[1][lookup_idx_i]) victim = 1'b1;
  end

  assign victim_o     = victim;
  assign victim_wb_o  = valid_q[victim][lookup_idx_i] & dirty_q[victim][lookup_idx_i];
  assign victim_tag_o = tag_q[victim][lookup_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM for the 2-way data cache: hit lookup in IDLE, optional
// dirty-victim write-back, line refill and array refresh.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  dcache_ctrl_if.master bus
);

  state_e state_q, state_d;
  logic   victim_q, victim_d;
  tag_t   victim_tag_q, victim_tag_d;
  tag_t   req_tag_q, req_tag_d;
  idx_t   req_idx_q, req_idx_d;
  addr_t  wr_addr_q, wr_addr_d;
  line_t  wr_data_q, wr_data_d;
  line_t  line_new_q, line_new_d;

  logic [HIT_WIDTH-1:0] match;
  logic                 victim, victim_wb;
  tag_t                 victim_tag;
  logic                 req;
  logic                 touch, clean, fill;
  logic [HIT_WIDTH-1:0] hit;
  logic                 stall, lru, write_back, refresh, rd_req, wr_req;
  logic                 unused_offset;

  assign req           = bus.cache & bus.sram_e;
  assign unused_offset = ^bus.sram_addr[OFFSET_WIDTH-1:0];

  dcache_tag u_tag (
    .clk           (clk),
    .rst           (rst),
    .lookup_idx_i  (addr_idx(bus.sram_addr)),
    .lookup_tag_i  (addr_tag(bus.sram_addr)),
    .match_o       (match),
    .victim_o      (victim),
    .victim_wb_o   (victim_wb),
    .victim_tag_o  (victim_tag),
    .touch_i       (touch),
    .touch_way_i   (match[1]),
    .touch_dirty_i (bus.sram_we),
    .clean_i       (clean),
    .fill_i        (fill),
    .upd_way_i     (victim_q),
    .upd_idx_i     (req_idx_q),
    .fill_tag_i    (req_tag_q)
  );

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    victim_tag_d = victim_tag_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    line_new_d   = line_new_q;
    hit          = '0;
    stall        = 1'b1;
    lru          = 1'b0;
    write_back   = 1'b0;
    refresh      = 1'b0;
    rd_req       = 1'b0;
    wr_req       = 1'b0;
    touch        = 1'b0;
    clean        = 1'b0;
    fill         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stall = 1'b0;
        if (req) begin
          hit = match;
          if (|match) begin
            touch = 1'b1;
          end else begin
            stall        = 1'b1;
            victim_d     = victim;
            victim_tag_d = victim_tag;
            req_tag_d    = addr_tag(bus.sram_addr);
            req_idx_d    = addr_idx(bus.sram_addr);
            state_d      = victim_wb ? S_WB_RD : S_RD_REQ;
          end
        end
      end
      // The array reads way0 when lru is 1, hence the inversion here only.
      S_WB_RD: begin
        write_back = 1'b1;
        lru        = ~victim_q;
        state_d    = S_WB_CAP;
      end
      S_WB_CAP: begin
        wr_data_d = bus.cacheline_old;
        wr_addr_d = line_addr(victim_tag_q, req_idx_q);
        state_d   = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        wr_req = 1'b1;
        if (bus.wr_done) begin
          clean   = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        rd_req = 1'b1;
        if (bus.rd_valid) begin
          line_new_d = bus.rd_data;
          state_d    = S_REFRESH;
        end
      end
      S_REFRESH: begin
        refresh = 1'b1;
        lru     = victim_q;
        fill    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      victim_q     <= 1'b0;
      victim_tag_q <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      line_new_q   <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      victim_tag_q <= victim_tag_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      line_new_q   <= line_new_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.hit           = hit;
  assign bus.lru           = lru;
  assign bus.write_back    = write_back;
  assign bus.refresh       = refresh;
  assign bus.cacheline_new = line_new_q;
  assign bus.rd_req        = rd_req;
  assign bus.rd_addr       = line_addr(req_tag_q, req_idx_q);
  assign bus.wr_req        = wr_req;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses push expected bus/array
// events; a negedge monitor pops and compares them as the DUT presents them.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  typedef enum logic [2:0] {EV_WB, EV_WR, EV_RD, EV_REF, EV_HIT} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    addr_t      addr;
    line_t      data;
    logic [1:0] val;
  } exp_t;

  localparam line_t STORE_PAT = 128'h0123_4567_89ab_cdef_f0e1_d2c3_b4a5_9687;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   rd_lat = 0;
  int   wr_lat = 0;
  exp_t exp_q[$];
  line_t mem [2][NUM_SETS];

  dcache_ctrl_if bus();

  dcache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic line_t line_pat(input addr_t a);
    return {a ^ 64'ha5a5_0000_0000_0000, ~a};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input addr_t a, input line_t d, input logic [1:0] v);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.val = v;
    exp_q.push_back(e);
  endtask

  // Cold fill of a clean (or invalid) victim followed by the re-lookup hit.
  task automatic expect_fill(input addr_t a, input logic way);
    expect_ev(EV_RD,  a,  '0, 2'b00);
    expect_ev(EV_REF, '0, '0, {1'b0, way});
    expect_ev(EV_HIT, '0, '0, way ? 2'b10 : 2'b01);
  endtask

  task automatic pop(input ev_kind_e k, output exp_t e, output bit ok);
    e  = '0;
    ok = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL ev_unexpected: got=%s expected=none", k.name());
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == k);
      if (!ok) begin
        bad++;
        $display("FAIL ev_order: got=%s expected=%s", k.name(), e.kind.name());
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the access has hit.
  task automatic access(input addr_t a, input logic we);
    int n;
    n = 0;
    bus.cache = 1'b1; bus.sram_e = 1'b1; bus.sram_we = we; bus.sram_addr = a;
    do begin
      @(negedge clk);
      n++;
    end while (bus.stall && n < 200);
    check("access_done", 128'(bus.stall), 128'(0));
    @(posedge clk); #1;
    bus.cache = 1'b0; bus.sram_e = 1'b0; bus.sram_we = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"},   128'(bus.stall),      128'(0));
    check({tag, "_hit"},     128'(bus.hit),        128'(0));
    check({tag, "_lru"},     128'(bus.lru),        128'(0));
    check({tag, "_wb"},      128'(bus.write_back), 128'(0));
    check({tag, "_refresh"}, 128'(bus.refresh),    128'(0));
    check({tag, "_rd_req"},  128'(bus.rd_req),     128'(0));
    check({tag, "_wr_req"},  128'(bus.wr_req),     128'(0));
    check({tag, "_rd_addr"}, 128'(bus.rd_addr),    128'(0));
    check({tag, "_wr_addr"}, 128'(bus.wr_addr),    128'(0));
    check({tag, "_wr_data"}, bus.wr_data,          128'(0));
    check({tag, "_cl_new"},  bus.cacheline_new,    128'(0));
  endtask

  // Read responder: rd_lat idle cycles, 0 means same-cycle response.
  initial begin
    int cnt;
    cnt = 0;
    bus.rd_valid = 1'b0; bus.rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.rd_req) cnt = 0;
      else if (cnt >= rd_lat) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = line_pat(bus.rd_addr);
      end else cnt++;
      @(posedge clk); #1;
      if (bus.rd_valid) begin bus.rd_valid = 1'b0; cnt = 0; end
    end
  end

  // Write responder.
  initial begin
    int cnt;
    cnt = 0;
    bus.wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.wr_req) cnt = 0;
      else if (cnt >= wr_lat) bus.wr_done = 1'b1;
      else cnt++;
      @(posedge clk); #1;
      if (bus.wr_done) begin bus.wr_done = 1'b0; cnt = 0; end
    end
  end

  // Data array model: way returned for write_back is ~lru, line valid next cycle.
  initial begin
    line_t old_tmp;
    bit    wb_pend;
    int    idx;
    old_tmp = '0;
    bus.cacheline_old = '0;
    forever begin
      @(negedge clk);
      idx     = int'(bus.sram_addr[9:4]);
      wb_pend = bus.write_back;
      if (bus.write_back) old_tmp = mem[bus.lru ? 0 : 1][idx];
      if (bus.refresh) mem[bus.lru ? 1 : 0][idx] = bus.cacheline_new;
      if (bus.hit != 2'b00 && bus.sram_we) mem[bus.hit[1] ? 1 : 0][idx] ^= STORE_PAT;
      @(posedge clk); #1;
      if (wb_pend) bus.cacheline_old = old_tmp;
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e, cur_wr, cur_rd;
    bit   ok, wr_prev, rd_prev;
    int   active;
    wr_prev = 1'b0; rd_prev = 1'b0; cur_wr = '0; cur_rd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_prev = 1'b0; rd_prev = 1'b0;
        continue;
      end
      active = int'(bus.write_back) + int'(bus.refresh) + int'(bus.rd_req) + int'(bus.wr_req);
      if (active != 0) begin
        check("one_cmd",    128'(active),    128'(1));
        check("stall_busy", 128'(bus.stall), 128'(1));
        check("hit_busy",   128'(bus.hit),   128'(0));
      end
      if (bus.write_back) begin
        pop(EV_WB, e, ok);
        if (ok) check("wb_lru", 128'(bus.lru), 128'(e.val));
      end
      if (bus.wr_req) begin
        if (!wr_prev) begin
          pop(EV_WR, cur_wr, ok);
          if (ok) begin
            check("wr_addr", 128'(bus.wr_addr), 128'(cur_wr.addr));
            check("wr_data", bus.wr_data, cur_wr.data);
          end
        end else begin
          check("wr_addr_hold", 128'(bus.wr_addr), 128'(cur_wr.addr));
          check("wr_data_hold", bus.wr_data, cur_wr.data);
        end
      end
      wr_prev = bus.wr_req;
      if (bus.rd_req) begin
        if (!rd_prev) begin
          pop(EV_RD, cur_rd, ok);
          if (ok) check("rd_addr", 128'(bus.rd_addr), 128'(cur_rd.addr));
        end else begin
          check("rd_addr_hold", 128'(bus.rd_addr), 128'(cur_rd.addr));
        end
      end
      rd_prev = bus.rd_req;
      if (bus.refresh) begin
        pop(EV_REF, e, ok);
        if (ok) check("ref_lru", 128'(bus.lru), 128'(e.val));
      end
      if (bus.cache && bus.sram_e && !bus.stall) begin
        pop(EV_HIT, e, ok);
        if (ok) check("hit_way", 128'(bus.hit), 128'(e.val));
      end
    end
  end

  // Stimulus.
  initial begin
    int n;
    rst = 1'b1;
    bus.cache = 1'b0; bus.sram_e = 1'b0; bus.sram_we = 1'b0; bus.sram_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;

    // Uncacheable request is ignored.
    bus.sram_e = 1'b1; bus.sram_addr = 64'h8000_0010;
    @(negedge clk);
    check("nc_stall", 128'(bus.stall), 128'(0));
    check("nc_hit",   128'(bus.hit),   128'(0));
    @(negedge clk);
    check("nc_rd_req", 128'(bus.rd_req), 128'(0));
    @(posedge clk); #1;
    bus.sram_e = 1'b0;

    // Cold load, reload hit, store hit (set 1, way0).
    expect_fill(64'h8000_0010, 1'b0);
    access(64'h8000_0010, 1'b0);
    expect_ev(EV_HIT, '0, '0, 2'b01);
    access(64'h8000_0010, 1'b0);
    expect_ev(EV_HIT, '0, '0, 2'b01);
    access(64'h8000_0010, 1'b1);

    // Second way of set 1, then dirty eviction of way0 with 5-cycle responders.
    expect_fill(64'h8000_0410, 1'b1);
    access(64'h8000_0410, 1'b0);
    rd_lat = 5; wr_lat = 5;
    expect_ev(EV_WB, '0, '0, 2'b01);
    expect_ev(EV_WR, 64'h8000_0010, line_pat(64'h8000_0010) ^ STORE_PAT, 2'b00);
    expect_fill(64'h8000_0810, 1'b0);
    access(64'h8000_0810, 1'b0);
    rd_lat = 0; wr_lat = 0;

    // Way0 now holds a clean refill: evicting it again needs no write-back.
    expect_ev(EV_HIT, '0, '0, 2'b10);
    access(64'h8000_0410, 1'b0);
    expect_fill(64'h8000_0010, 1'b0);
    access(64'h8000_0010, 1'b0);

    // Conflict fill in set 2: third load evicts clean way0.
    expect_fill(64'h8000_0020, 1'b0);
    access(64'h8000_0020, 1'b0);
    expect_fill(64'h8000_0420, 1'b1);
    access(64'h8000_0420, 1'b0);
    expect_fill(64'h8000_0820, 1'b0);
    access(64'h8000_0820, 1'b0);

    // Set 3: dirty way0, then reset while the write-back waits.
    expect_fill(64'h8000_0030, 1'b0);
    access(64'h8000_0030, 1'b1);
    expect_fill(64'h8000_0430, 1'b1);
    access(64'h8000_0430, 1'b0);
    wr_lat = 20;
    expect_ev(EV_WB, '0, '0, 2'b01);
    expect_ev(EV_WR, 64'h8000_0030, line_pat(64'h8000_0030) ^ STORE_PAT, 2'b00);
    bus.cache = 1'b1; bus.sram_e = 1'b1; bus.sram_we = 1'b0; bus.sram_addr = 64'h8000_0830;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wr_req && n < 50);
    check("reach_wb_wait", 128'(bus.wr_req), 128'(1));
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; bus.cache = 1'b0; bus.sram_e = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; wr_lat = 0;
    @(negedge clk);
    check_quiet("midrst");
    @(posedge clk); #1;

    // Valid bits were cleared: previously cached lines miss again.
    expect_fill(64'h8000_0010, 1'b0);
    access(64'h8000_0010, 1'b0);
    expect_fill(64'h8000_0030, 1'b0);
    access(64'h8000_0030, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Miss-handling controller and tag store for the 2-way, 64-set, 16-byte-line data cache.
- Sits directly upstream of the dcache data array. It drives that array's hit, lru, write_back, refresh and cacheline_new inputs, and consumes its cacheline_old output.
- Holds the tag, valid, dirty and per-set LRU state.
- Sequences write-back and refill of whole 128-bit lines over a simplified line-granular bus interface.

Parameters:
- TAG_W, 54, tag width (addr[63:10]).
- IDX_W, 6, set index width (addr[9:4]).
- OFF_W, 4, byte offset within a line (addr[3:0]).
- LINE_W, 128, line width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cache  in  1  access is cacheable; when 0 the request is ignored (stall=0, hit=0).
- sram_e  in  1  CPU access valid.
- sram_we  in  1  CPU store.
- sram_addr  in  64  CPU byte address.
- stall  out  1  CPU must hold its request.
- hit  out  2  one-hot hit way, to the data array.
- lru  out  1  way select for write_back/refresh, to the data array.
- write_back  out  1  read victim line from the data array.
- refresh  out  1  write cacheline_new into the victim way.
- cacheline_new  out  128  refill line, to the data array.
- cacheline_old  in  128  victim line from the data array, valid the cycle after write_back.
- rd_req  out  1  line read request.
- rd_addr  out  64  line-aligned read address.
- rd_valid  in  1  rd_data valid; completes the read.
- rd_data  in  128  refill line.
- wr_req  out  1  line write request.
- wr_addr  out  64  line-aligned write address.
- wr_data  out  128  victim line.
- wr_done  in  1  write accepted; completes the write.

Behaviour:
- State: tag[2][64], valid[2][64], dirty[2][64], mru[64] (way last touched).
- Reset clears valid, dirty and mru; tags are don't-care. Reset also clears every output and puts the FSM in IDLE.
- Lookup is combinational in IDLE: hit[w] = cache & sram_e & valid[w][idx] & tag[w][idx]==addr tag.
- Hit, IDLE state:
  - stall=0; data returns from the array 1 cycle later.
  - mru[idx] <= hit way.
  - A store also sets dirty[w][idx] <= 1.
- Miss in IDLE (cache & sram_e & hit==0):
  - stall=1 combinationally that same cycle.
  - Victim selection: an invalid way is chosen first (way0 when both are invalid); otherwise victim = ~mru[idx].
  - The victim is latched, together with the address.
  - Next state: WB_RD if the victim is valid and dirty, else RD_REQ.
- WB_RD:
  - write_back=1 and lru=~victim for 1 cycle, because the array returns way0 when the registered lru is 1.
  - Next state: WB_CAP.
- WB_CAP:
  - Latch wr_data <= cacheline_old.
  - wr_addr <= {victim tag, idx, 4'b0}.
  - Next state: WB_WAIT.
- WB_WAIT:
  - wr_req held at 1 until wr_done is sampled high.
  - Then wr_req=0, dirty[victim][idx] <= 0, next state RD_REQ.
- RD_REQ:
  - rd_req=1, rd_addr={addr tag, idx, 4'b0}; both held until rd_valid.
  - On rd_valid: latch rd_data into cacheline_new, rd_req=0, next state REFRESH.
- REFRESH:
  - refresh=1 and lru=victim for 1 cycle (lru=0 writes way0).
  - tag/valid[victim][idx] <= new tag/1, dirty <= 0.
  - Next state: IDLE.
- Back in IDLE the held request is re-looked-up and hits: stall drops, and a store's data is written through the normal hit path.
- stall is 1 in every state except IDLE.
- write_back, refresh, rd_req and wr_req are mutually exclusive.
- hit=0 in all non-IDLE states, so no array writes occur during a miss.
- rd_valid or wr_done arriving in the same cycle the request is first raised is accepted (0-wait responder).
- Responses outside the matching WAIT/REQ state are ignored.
- Reset mid-miss: the FSM returns to IDLE, requests drop immediately and the latched line is discarded. Bus responders must also be reset.
- Index/tag slicing is fixed: addr[63:10] tag, addr[9:4] index.

Decomposition:
- Shared defines: TAG_WIDTH, INDEX_WIDTH, OFFSET_WIDTH, AXI_RW_DATA_WIDTH, HIT_WIDTH, FSM state encodings.
- Sub-module dcache_tag (tag/valid/dirty/mru arrays with combinational compare and victim select). The FSM stays in dcache_ctrl.

Test Plan:
- Cold load 0x8000_0010 after reset:
  - stall for RD_REQ, REFRESH.
  - rd_addr=0x8000_0010, refresh with lru=0.
  - Reload of the same address hits with hit=2'b01 and stall=0.
- Store hit to 0x8000_0010:
  - hit=01, no bus traffic.
  - Evicting that line later requires a write_back with lru=1 and wr_addr=0x8000_0010.
- Conflict fill, 3 loads in set 1 (0x8000_0010, 0x8000_0410, 0x8000_0810):
  - Third load evicts way0 (clean).
  - No wr_req; refresh lru=0.
- Dirty eviction:
  - Sequence: store to 0x8000_0010, load 0x8000_0410, load 0x8000_0810.
  - Required: wr_data equals the array line; wr_req precedes rd_req; dirty clears.
- 5-cycle delayed wr_done and rd_valid:
  - rd_req/wr_req and addresses stay stable until the response.
  - stall=1 throughout.
- rst asserted during WB_WAIT:
  - Next cycle: all outputs 0, state IDLE, all valid bits clear.
  - Next access misses.
